// File: rtl/program_write_sink.sv
// -----------------------------------------------------------------------------
// program_write_sink
//
// Responder end of the pixel program interface. Pixel writes from the copy
// engine are mapped to a frame-buffer word address, queued in a FIFO and
// replayed as single-cycle SRAM writes whenever the SRAM controller grants a
// write slot. The block also owns the double-buffer frame select: every write
// targets the back frame (~current_frame), and a swap request first drains the
// FIFO (including the last in-flight SRAM write) before flipping the frame.
//
// Parameters
//   Depth          FIFO entries (power of two, >= 2)
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high
//   program_x      pixel column (0..639)
//   program_y      pixel row (0..479)
//   program_data   RGB565 pixel
//   program_write  write strobe, one pixel per cycle
//   program_full   backpressure; writes presented while high are rejected
//   write_slot     SRAM controller grants one write this cycle
//   sram_w_addr    SRAM word address (registered)
//   sram_w_data    SRAM write data (registered)
//   sram_w_en      one-cycle SRAM write pulse (registered)
//   swap_req       pulse requesting a frame swap
//   swap_done      one-cycle pulse when the swap completes (registered)
//   current_frame  front frame being displayed (registered)
//   overflow       sticky flag: a write was rejected (registered)
//
// Build option
//   PROGRAM_CLIP_EN  when defined, writes with x >= 640 or y >= 480 are
//                    silently discarded (no FIFO entry, no overflow). When
//                    undefined, out-of-range coordinates alias through the
//                    truncated y[8:0]/x[9:0] address fields.
// -----------------------------------------------------------------------------
module program_write_sink #(
  parameter int Depth = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  program_x,
  input  logic [9:0]  program_y,
  input  logic [15:0] program_data,
  input  logic        program_write,
  output logic        program_full,
  input  logic        write_slot,
  output logic [19:0] sram_w_addr,
  output logic [15:0] sram_w_data,
  output logic        sram_w_en,
  input  logic        swap_req,
  output logic        swap_done,
  output logic        current_frame,
  output logic        overflow
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = PtrW + 1;
  localparam int EntryW = 36;

  localparam logic [CntW-1:0] CountFull = CntW'(Depth);
  localparam logic [CntW-1:0] CountZero = {CntW{1'b0}};
  localparam logic [CntW-1:0] CountOne  = {{PtrW{1'b0}}, 1'b1};
  localparam logic [PtrW-1:0] PtrZero   = {PtrW{1'b0}};
  localparam logic [PtrW-1:0] PtrOne    = {{(PtrW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2
  } state_e;

  // Frame-buffer word address: back frame in the MSB, then row, then column.
  function automatic logic [19:0] map_addr(
    input logic       frame,
    input logic [8:0] row,
    input logic [9:0] col
  );
    map_addr = {frame, row, col};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [EntryW-1:0] mem_q [Depth];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q,  count_d;

  logic [19:0] sram_w_addr_q, sram_w_addr_d;
  logic [15:0] sram_w_data_q, sram_w_data_d;
  logic        sram_w_en_q,   sram_w_en_d;

  state_e state_q, state_d;
  logic   current_frame_q, current_frame_d;
  logic   swap_done_q,     swap_done_d;
  logic   overflow_q,      overflow_d;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic              program_full_s;
  logic              in_range_s;
  logic              push_s;
  logic              pop_s;
  logic              reject_s;
  logic [EntryW-1:0] push_entry_s;
  logic [EntryW-1:0] head_entry_s;

`ifdef PROGRAM_CLIP_EN
  assign in_range_s = (program_x < 10'd640) && (program_y < 10'd480);
`else
  // Without clipping the row MSB never reaches the address map.
  logic unused_y_msb_s;
  assign in_range_s     = 1'b1;
  assign unused_y_msb_s = program_y[9];
`endif

  // Backpressure and push/pop qualification, all from registered state.
  always_comb begin
    program_full_s = (count_q == CountFull) || (state_q != IDLE);
    // A full-rejected write flags overflow even if it would also be clipped.
    reject_s       = program_write && program_full_s;
    push_s         = program_write && !program_full_s && in_range_s;
    // Pop is judged on count before the edge, so a fresh push cannot bypass.
    pop_s          = write_slot && (count_q != CountZero);
    push_entry_s   = {map_addr(~current_frame_q, program_y[8:0], program_x),
                      program_data};
    head_entry_s   = mem_q[rd_ptr_q];
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  // Next pointer/count values; simultaneous push and pop leave count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push_s && !pop_s) begin
      count_d = count_q + CountOne;
    end else if (!push_s && pop_s) begin
      count_d = count_q - CountOne;
    end else begin
      count_d = count_q;
    end
  end

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      mem_q[wr_ptr_q] <= push_entry_s;
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM write port
  // ---------------------------------------------------------------------------
  // Pop registers the head entry; address/data hold between pulses.
  always_comb begin
    sram_w_en_d   = pop_s;
    sram_w_addr_d = sram_w_addr_q;
    sram_w_data_d = sram_w_data_q;
    if (pop_s) begin
      sram_w_addr_d = head_entry_s[35:16];
      sram_w_data_d = head_entry_s[15:0];
    end else begin
      sram_w_addr_d = sram_w_addr_q;
      sram_w_data_d = sram_w_data_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Overflow flag
  // ---------------------------------------------------------------------------
  // Sticky until reset.
  always_comb begin
    overflow_d = overflow_q;
    if (reject_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame swap FSM
  // ---------------------------------------------------------------------------
  // DRAIN waits for both an empty FIFO and the last SRAM pulse to retire so
  // no pixel written to the old back frame lands after the flip.
  always_comb begin
    state_d         = state_q;
    current_frame_d = current_frame_q;
    swap_done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (swap_req) begin
          state_d = DRAIN;
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if ((count_q == CountZero) && !sram_w_en_q) begin
          state_d = SWAP;
        end else begin
          state_d = DRAIN;
        end
      end
      SWAP: begin
        state_d         = IDLE;
        current_frame_d = ~current_frame_q;
        swap_done_d     = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // All control and output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q        <= PtrZero;
      rd_ptr_q        <= PtrZero;
      count_q         <= CountZero;
      sram_w_addr_q   <= 20'h00000;
      sram_w_data_q   <= 16'h0000;
      sram_w_en_q     <= 1'b0;
      state_q         <= IDLE;
      current_frame_q <= 1'b0;
      swap_done_q     <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      sram_w_addr_q   <= sram_w_addr_d;
      sram_w_data_q   <= sram_w_data_d;
      sram_w_en_q     <= sram_w_en_d;
      state_q         <= state_d;
      current_frame_q <= current_frame_d;
      swap_done_q     <= swap_done_d;
      overflow_q      <= overflow_d;
    end
  end

  assign program_full  = program_full_s;
  assign sram_w_addr   = sram_w_addr_q;
  assign sram_w_data   = sram_w_data_q;
  assign sram_w_en     = sram_w_en_q;
  assign swap_done     = swap_done_q;
  assign current_frame = current_frame_q;
  assign overflow      = overflow_q;

endmodule
